// File: rtl/mul3_seq.sv
// Sequential reconstruction o = q*3 + r using repeated addition of 3.
// Define MUL3_SHIFT_ADD_EN to compute the result in one step with a shift-add instead.
module mul3_seq #(
    parameter int QW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [QW-1:0] q,
    input  logic [1:0]    r,
    output logic [QW+1:0] o,
    output logic          busy,
    output logic          done,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, ADD, FIN} state_t;

    state_t        state_q, state_d;
    logic [QW+1:0] o_q, o_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
`ifndef MUL3_SHIFT_ADD_EN
    logic [QW-1:0] cnt_q, cnt_d;
    logic [QW+1:0] acc_q, acc_d;
`endif

    always_comb begin
        state_d = state_q;
        o_d     = o_q;
        err_d   = err_q;
`ifndef MUL3_SHIFT_ADD_EN
        cnt_d   = cnt_q;
        acc_d   = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (r == 2'd3) begin
                        // Illegal remainder: report immediately, nothing to reconstruct.
                        err_d   = 1'b1;
                        o_d     = '0;
                        state_d = FIN;
                    end else begin
                        err_d   = 1'b0;
`ifdef MUL3_SHIFT_ADD_EN
                        o_d     = ({2'b00, q} << 1) + {2'b00, q} + {{QW{1'b0}}, r};
                        state_d = FIN;
`else
                        cnt_d   = q;
                        acc_d   = {{QW{1'b0}}, r};
                        state_d = ADD;
`endif
                    end
                end
            end
`ifndef MUL3_SHIFT_ADD_EN
            ADD: begin
                if (cnt_q != '0) begin
                    acc_d = acc_q + (QW+2)'(3);
                    cnt_d = cnt_q - QW'(1);
                end else begin
                    o_d     = acc_q;
                    state_d = FIN;
                end
            end
`endif
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Handshake outputs are registered from the next state.
        busy_d = (state_d == ADD);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            o_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifndef MUL3_SHIFT_ADD_EN
            cnt_q   <= '0;
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifndef MUL3_SHIFT_ADD_EN
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
`endif
        end
    end

    assign o    = o_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
endmodule

// File: tb/tb_mul3_seq.sv
// Self-checking bench for mul3_seq: randomized and directed operations against an arithmetic model.
module tb_mul3_seq;
    localparam int QW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [QW-1:0] q = '0;
    logic [1:0]    r = '0;
    logic [QW+1:0] o;
    logic          busy, done, err;

    int vectors = 0;
    int miscompares = 0;

    mul3_seq #(.QW(QW)) dut (
        .clk(clk), .rst(rst), .start(start), .q(q), .r(r),
        .o(o), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Model: result value and cycles from the start cycle to the done cycle.
    function automatic int exp_lat(input int qv, input int rv);
`ifdef MUL3_SHIFT_ADD_EN
        return 1;
`else
        return (rv == 3) ? 1 : qv + 2;
`endif
    endfunction

    function automatic int exp_busy(input int qv, input int rv);
`ifdef MUL3_SHIFT_ADD_EN
        return 0;
`else
        return (rv == 3) ? 0 : qv + 1;
`endif
    endfunction

    // Stimulus: pulse start for one cycle and observe until done (bounded).
    task automatic run_op(input int qv, input int rv, output int lat, output int bcnt,
                          output logic [QW+1:0] ov, output logic ev);
        @(negedge clk);
        q = qv[QW-1:0]; r = rv[1:0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
        ov = o; ev = err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({o, busy, done, err} !== '0) begin
            miscompares++;
            $display("FAIL reset: o=%0d busy=%b done=%b err=%b, required all zero", o, busy, done, err);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bcnt; logic [QW+1:0] ov; logic ev;
        int tq[3] = '{3, 0, 7};
        int tr[3] = '{1, 2, 2};
        for (int i = 0; i < 3; i++) begin
            run_op(tq[i], tr[i], lat, bcnt, ov, ev);
            vectors++;
            if (ov !== 5'(tq[i] * 3 + tr[i]) || ev !== 1'b0 || lat != exp_lat(tq[i], tr[i])
                || bcnt != exp_busy(tq[i], tr[i])) begin
                miscompares++;
                $display("FAIL basic q=%0d r=%0d: o=%0d err=%b lat=%0d busy=%0d, required o=%0d err=0 lat=%0d busy=%0d",
                         tq[i], tr[i], ov, ev, lat, bcnt, tq[i] * 3 + tr[i], exp_lat(tq[i], tr[i]), exp_busy(tq[i], tr[i]));
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0) begin
                miscompares++;
                $display("FAIL done_width q=%0d: done=%b one cycle after pulse, required 0", tq[i], done);
            end
        end
    endtask

    task automatic test_illegal();
        int lat, bcnt; logic [QW+1:0] ov; logic ev;
        run_op(5, 3, lat, bcnt, ov, ev);
        vectors++;
        if (ov !== '0 || ev !== 1'b1 || lat != 1) begin
            miscompares++;
            $display("FAIL illegal_r: o=%0d err=%b lat=%0d, required o=0 err=1 lat=1", ov, ev, lat);
        end
        @(negedge clk);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_hold: err=%b after done, required 1", err);
        end
        run_op(1, 0, lat, bcnt, ov, ev);
        vectors++;
        if (ov !== 5'd3 || ev !== 1'b0 || lat != exp_lat(1, 0)) begin
            miscompares++;
            $display("FAIL after_illegal: o=%0d err=%b lat=%0d, required o=3 err=0 lat=%0d", ov, ev, lat, exp_lat(1, 0));
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        logic [QW+1:0] prev_o = o;
        @(negedge clk);
        q = 3'd6; r = 2'd0; start = 1'b1;
        @(negedge clk);
        q = 3'd1; r = 2'd2;
        vectors++;
        if (busy && o !== prev_o) begin
            miscompares++;
            $display("FAIL o_hold: o=%0d while busy, required %0d", o, prev_o);
        end
        if (done) dones++;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        vectors++;
        if (dones != 1 || o !== 5'd18) begin
            miscompares++;
            $display("FAIL ignore_start: dones=%0d o=%0d, required dones=1 o=18", dones, o);
        end
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        int lat, bcnt; logic [QW+1:0] ov; logic ev;
        @(negedge clk);
        q = 3'd7; r = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (o !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_abort: o=%0d busy=%b done=%b, required 0 0 0", o, busy, done);
        end
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL abort_done: %0d done pulses after reset, required 0", dones);
        end
        run_op(2, 1, lat, bcnt, ov, ev);
        vectors++;
        if (ov !== 5'd7 || ev !== 1'b0) begin
            miscompares++;
            $display("FAIL after_abort: o=%0d err=%b, required o=7 err=0", ov, ev);
        end
    endtask

    // Round trip: every dividend 0..23 split into quotient/remainder must come back intact.
    task automatic test_sweep();
        int lat, bcnt; logic [QW+1:0] ov; logic ev;
        for (int i = 0; i < 24; i++) begin
            run_op(i / 3, i % 3, lat, bcnt, ov, ev);
            vectors++;
            if (ov !== 5'(i) || ev !== 1'b0 || lat != exp_lat(i / 3, i % 3)) begin
                miscompares++;
                $display("FAIL sweep i=%0d: o=%0d err=%b lat=%0d, required o=%0d err=0 lat=%0d",
                         i, ov, ev, lat, i, exp_lat(i / 3, i % 3));
            end
        end
    endtask

    task automatic test_random();
        int lat, bcnt; logic [QW+1:0] ov; logic ev;
        for (int n = 0; n < 30; n++) begin
            int qv = int'($urandom_range(7, 0));
            int rv = int'($urandom_range(3, 0));
            int eo = (rv == 3) ? 0 : qv * 3 + rv;
            run_op(qv, rv, lat, bcnt, ov, ev);
            vectors++;
            if (ov !== 5'(eo) || ev !== (rv == 3) || lat != exp_lat(qv, rv) || bcnt != exp_busy(qv, rv)) begin
                miscompares++;
                $display("FAIL random q=%0d r=%0d: o=%0d err=%b lat=%0d busy=%0d, required o=%0d err=%0d lat=%0d busy=%0d",
                         qv, rv, ov, ev, lat, bcnt, eo, rv == 3, exp_lat(qv, rv), exp_busy(qv, rv));
            end
        end
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1;
        @(negedge clk);
        q = 3'd2; r = 2'd1; start = 1'b1;
        for (int c = 1; c < 40 && second < 0; c++) begin
            @(negedge clk);
            if (done) begin
                if (first < 0) first = c;
                else second = c;
            end
        end
        start = 1'b0;
        vectors++;
        // Second op is sampled in the IDLE cycle right after FIN.
        if (first != exp_lat(2, 1) || second != 2 * exp_lat(2, 1) + 1 || o !== 5'd7) begin
            miscompares++;
            $display("FAIL back_to_back: dones at %0d,%0d o=%0d, required %0d,%0d o=7",
                     first, second, o, exp_lat(2, 1), 2 * exp_lat(2, 1) + 1);
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_ignore_start();
        test_reset_abort();
        test_sweep();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
